// File: rtl/ahb_lite_initiator.sv
// AHB-Lite single-transfer initiator.
// Takes one command at a time, runs it as a single NONSEQ transfer and returns
// one response carrying read data, error flags and the number of data-phase
// wait states. Misaligned or illegal-size commands never reach the bus.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command (cmd_ready high)
// ADDR  | address phase, HTRANS=NONSEQ, held until HREADY
// DATA  | data phase, counting wait states and watching HRESP
// RESP  | response presented on rsp_*, waits for rsp_ready
module ahb_lite_initiator #(
    parameter int WAIT_W = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [31:0]       cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [2:0]        cmd_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_misalign,
    output logic [WAIT_W-1:0] rsp_waits,
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              cmd_bad;
    logic              err_q;
    logic [WAIT_W-1:0] wait_cnt;

    assign accept  = (state == S_IDLE) && cmd_valid;
    assign cmd_bad = (cmd_size > 3'd2) ||
                     ((cmd_size == 3'd1) && cmd_addr[0]) ||
                     ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));

    assign rsp_waits = wait_cnt;

    // State register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_nxt = state;
        HTRANS    = 2'b00;
        rsp_valid = 1'b0;
        cmd_ready = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = HRESETn;
                if (cmd_valid) begin
                    state_nxt = cmd_bad ? S_RESP : S_ADDR;
                end
            end
            S_ADDR: begin
                HTRANS = 2'b10;
                if (HREADY) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command capture, wait counting, error latch and response fields
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            HADDR        <= '0;
            HWRITE       <= 1'b0;
            HSIZE        <= '0;
            HWDATA       <= '0;
            wait_cnt     <= '0;
            err_q        <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_misalign <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt     <= '0;
                err_q        <= 1'b0;
                rsp_rdata    <= '0;
                rsp_err      <= cmd_bad;
                rsp_misalign <= cmd_bad;
                // Rejected commands leave the bus-facing registers untouched.
                if (!cmd_bad) begin
                    HADDR  <= cmd_addr;
                    HWRITE <= cmd_write;
                    HSIZE  <= cmd_size;
                    // HWDATA only tracks writes so a read leaves it unchanged.
                    if (cmd_write) begin
                        HWDATA <= cmd_wdata;
                    end
                end
            end
            if (state == S_DATA) begin
                if (!HREADY) begin
                    if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    if (HRESP) begin
                        err_q <= 1'b1;
                    end
                end else begin
                    rsp_err <= HRESP | err_q;
                    if (!HWRITE && !HRESP && !err_q) begin
                        rsp_rdata <= HRDATA;
                    end
                end
            end
        end
    end

endmodule

// File: doc/ahb_lite_initiator.md
AHB_LITE_INITIATOR -- requirements
Module: ahb_lite_initiator

Interface
REQ-001 Parameter: WAIT_W, default 8, width of the saturating wait-state counter reported per transaction.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 HCLK  input  1  clock; all state updates on rising edge.
REQ-004 HRESETn  input  1  synchronous active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-007 cmd_write  input  1  1 write, 0 read.
REQ-008 cmd_addr  input  32  byte address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 cmd_size  input  3  AHB HSIZE encoding; only 0 (byte), 1 (half), 2 (word) legal.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  bus error or rejected command.
REQ-015 rsp_misalign  output  1  command rejected locally (misaligned or illegal size); no bus transfer issued.
REQ-016 rsp_waits  output  WAIT_W  data-phase wait states of this transaction, saturating.
REQ-017 HADDR  output  32; HTRANS  output  2; HWRITE  output  1; HSIZE  output  3; HWDATA  output  32: AHB-Lite initiator outputs.
REQ-018 HRDATA  input  32; HREADY  input  1; HRESP  input  1: AHB-Lite responder returns.

Function
REQ-019 FSM states IDLE, ADDR, DATA, RESP; single outstanding transfer, no bursts, no pipelining of back-to-back transfers.
REQ-020 cmd_ready SHALL be 1 only in IDLE.
REQ-021 IDLE, accept with misaligned address (size 1 and addr[0]=1; size 2 and addr[1:0]!=0) or size>2: go to RESP with rsp_err=1, rsp_misalign=1, rsp_waits=0, HTRANS kept IDLE.
REQ-022 IDLE, legal accept: register addr/write/size/wdata; go to ADDR.
REQ-023 ADDR: HTRANS=2'b10 (NONSEQ), HADDR/HWRITE/HSIZE from registered command; stay while HREADY=0; on HREADY=1 go to DATA.
REQ-024 HTRANS SHALL be 2'b00 (IDLE) in every state other than ADDR; HADDR/HWRITE/HSIZE hold last values outside ADDR.
REQ-025 DATA: HWDATA = registered wdata (held through the whole data phase); wait counter increments each DATA cycle with HREADY=0, saturating at 2^WAIT_W-1, cleared on command accept.
REQ-026 DATA, HREADY=0 and HRESP=1 (first error cycle): remain in DATA, latch error.
REQ-027 DATA, HREADY=1: capture HRDATA for reads when HRESP=0 and no latched error; rsp_err = HRESP OR latched error; go to RESP.
REQ-028 RESP: rsp_valid=1, response fields stable; on rsp_ready=1 return to IDLE next cycle; rsp_ready ignored outside RESP.
REQ-029 Zero-wait latency: accept at edge N, NONSEQ during cycle N+1, data phase N+2, rsp_valid during N+3; next accept no earlier than cycle N+4.
REQ-030 HREADY sampled in IDLE or RESP SHALL have no effect.

Reset
REQ-031 On HRESETn=0 at a rising edge: state IDLE, HTRANS=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_misalign=0, rsp_waits=0, cmd_ready=0 while HRESETn=0, 1 from the first cycle after release.
REQ-032 Reset asserted mid-transfer (any state) SHALL abandon it: no response produced, HTRANS=IDLE from the next cycle.

Verification
REQ-033 Word write addr 0x3000_0000, data 0xDEADBEEF, zero waits -> one NONSEQ cycle, HWDATA=0xDEADBEEF in data phase, rsp_valid 3 cycles after accept, rsp_err=0, rsp_waits=0.
REQ-034 Word read addr 0x3FFF_FFFC, responder inserts 3 wait states returning 0x1234_5678 -> rsp_rdata=0x1234_5678, rsp_waits=3, HWDATA unchanged.
REQ-035 Half-word read addr 0x3000_0001 and size=3 command -> rsp_err=1, rsp_misalign=1, HTRANS never NONSEQ.
REQ-036 Two-cycle ERROR response (HREADY=0/HRESP=1 then HREADY=1/HRESP=1) on a read -> rsp_err=1, rsp_rdata=0, rsp_misalign=0.
REQ-037 rsp_ready held low 5 cycles -> rsp_valid and fields stable, cmd_ready=0 throughout; accept resumes after handshake.
REQ-038 HRESETn low during DATA with HREADY=0 -> no rsp_valid, all outputs at REQ-031 values, fresh command afterwards completes normally.
